dsram_axi_bridge: RTL and testbench
===================================

Name: dsram_axi_bridge

Overview:
- Converts the core's SRAM-style data port (en/wen/addr/wdata/rdata) into single-beat AXI4 read and write transactions.
- Sits directly downstream of the mips core's data_sram interface and upstream of the AXI interconnect.
- Adds a stall output back to the core and allows one outstanding transaction.

Parameters:
- None. Top level ties off the fixed AXI fields: id=1, len=0, burst=INCR, wlast=1, cache/prot/lock=0.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req  in  1  data_sram_en from core
wen  in  4  byte write strobes; 0 means read
addr  in  32  physical byte address, already translated by core
wdata  in  32  store data, already byte-lane aligned
rdata  out  32  load data, valid in DONE cycle, held until next read completes
stall  out  1  core must freeze pipeline while high
err  out  1  one-cycle pulse on rresp/bresp != OKAY
araddr  out  32  read address
arsize  out  3  always 3'b010
arvalid  out  1  AR valid
arready  in  1  AR ready
r_data  in  32  R data
rresp  in  2  R response
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  derived from wen
awvalid  out  1  AW valid
awready  in  1  AW ready
w_data  out  32  W data
wstrb  out  4  equals latched wen
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  B response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- Reset (async, resetn=0): state=IDLE; all valid/ready outputs=0; rdata=0; err=0; aw_done=w_done=0.
- IDLE:
  - req & wen==0: latch addr, go to RD_AR.
  - req & wen!=0: latch addr/wdata/wen, go to WR_AW_W.
  - No AXI signal is asserted in IDLE itself.
- RD_AR: arvalid=1, araddr=latched addr with [1:0] forced to 0. On arready, go to RD_R.
- RD_R: rready=1. On rvalid, capture r_data into rdata and go to DONE; err pulses if rresp!=0.
- WR_AW_W:
  - awvalid and wvalid both asserted, each deasserted independently after its own handshake (aw_done/w_done flags).
  - Go to WR_B in the cycle the second handshake completes; simultaneous handshakes go to WR_B directly.
  - awaddr = latched addr (low bits kept).
  - awsize: popcount(wen) 1 -> 0, 2 -> 1, 4 -> 2; other patterns -> 2.
- WR_B: bready=1. On bvalid, go to DONE; err pulses if bresp!=0.
- DONE: lasts exactly one cycle, stall=0, rdata valid, then unconditionally returns to IDLE.
- stall = (IDLE & req) | (state not in {IDLE, DONE}). Minimum latency is 4 cycles for a read (IDLE, AR, R, DONE).
- The core holds req/addr/wen/wdata stable while stall=1. The bridge latches its inputs on leaving IDLE and ignores later changes.
- Back-to-back requests: a new req present in the cycle after DONE is handled in IDLE like any other. There is no request pipelining.
- Valids, once raised, stay high until their handshake completes (AXI rule), regardless of core inputs.
- Reset mid-transaction abandons the outstanding transaction; interconnect reset is global.
- Error responses do not retry. Read data is still returned; err is the only indication.

Decomposition:
- Shared package axi_defs: AXI_SIZE_BYTE/HALF/WORD, RESP_OKAY/EXOKAY/SLVERR/DECERR, bridge state encoding.
- Sub-module strb_to_size (combinational, 4-bit strobe to 3-bit size).
- Same bridge, instantiated with wen=0, serves the instruction port later.

Test Plan:
- Read: req=1, wen=0, addr=0x1FC0_0104; arready after 2 cycles; rvalid with 0xDEADBEEF 1 cycle later -> araddr=0x1FC0_0104, arsize=2, stall high until DONE, rdata=0xDEADBEEF in DONE, stall=0 for that one cycle.
- Byte store: wen=4'b0100, addr=0x0000_0012, wdata=0x00AB_0000 -> awsize=0, wstrb=4'b0100, awaddr=0x12, w_data=0x00AB_0000; DONE only after bvalid.
- Split handshake: wready 3 cycles before awready -> wvalid drops right after the W handshake, awvalid held until awready, a single transition to WR_B, no duplicate W beat.
- Error: rresp=2'b10 -> err high exactly one cycle, state reaches DONE, rdata captured.
- Reset mid-op: resetn=0 while in WR_B -> same cycle (async) all valids=0, stall=0, state=IDLE; after release a new read completes normally.
- Back-to-back: read immediately followed by halfword store (wen=4'b0011) -> second transaction starts from IDLE the cycle after DONE, awsize=1.

Source files
------------

// File: rtl/dsram_axi_bridge_pkg.sv
// Shared AXI field encodings and the bridge state type for the SRAM-to-AXI data port bridge.
package axi_defs;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_AR,
    ST_RD_R,
    ST_WR_AW_W,
    ST_WR_B,
    ST_DONE
  } bridge_state_e;

endpackage

// File: rtl/dsram_axi_bridge_strb_to_size.sv
// Maps a byte-strobe pattern to an AXI transfer size; irregular patterns fall back to a full word.
module strb_to_size
  import axi_defs::*;
(
  input  logic [3:0] strb,
  output logic [2:0] size
);

  logic [2:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, strb[i]};
    end
    case (cnt)
      3'd1:    size = AXI_SIZE_BYTE;
      3'd2:    size = AXI_SIZE_HALF;
      default: size = AXI_SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/dsram_axi_bridge.sv
// SRAM-style core data port to single-beat AXI4 bridge, one outstanding transaction, stalls the core meanwhile.
module dsram_axi_bridge
  import axi_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] r_data,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] w_data,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_e state, state_nx;
  logic          aw_done, w_done, aw_done_nx, w_done_nx;
  logic          aw_hs, w_hs;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wen_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      aw_done <= aw_done_nx;
      w_done  <= w_done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    stall      = 1'b1;
    case (state)
      ST_IDLE: begin
        stall = req;
        if (req) state_nx = (wen == 4'b0000) ? ST_RD_AR : ST_WR_AW_W;
      end
      ST_RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nx = ST_RD_R;
      end
      ST_RD_R: begin
        rready = 1'b1;
        if (rvalid) state_nx = ST_DONE;
      end
      ST_WR_AW_W: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        // Flags clear on exit so the next write starts with both channels pending.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nx   = ST_WR_B;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end else begin
          aw_done_nx = aw_done || aw_hs;
          w_done_nx  = w_done || w_hs;
        end
      end
      ST_WR_B: begin
        bready = 1'b1;
        if (bvalid) state_nx = ST_DONE;
      end
      ST_DONE: begin
        stall    = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      if (state == ST_IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wen_q   <= wen;
      end
      if (state == ST_RD_R && rvalid) rdata <= r_data;
      err <= (state == ST_RD_R && rvalid && rresp != RESP_OKAY) ||
             (state == ST_WR_B && bvalid && bresp != RESP_OKAY);
    end
  end

  strb_to_size u_strb_to_size (
    .strb (wen_q),
    .size (awsize)
  );

  assign araddr = {addr_q[31:2], 2'b00};
  assign arsize = AXI_SIZE_WORD;
  assign awaddr = addr_q;
  assign w_data = wdata_q;
  assign wstrb  = wen_q;

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Directed and randomized transactions against a transaction-level model of the bridge's cycle timing.
module tb_dsram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] r_data;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] w_data;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [31:0] last_rdata;

  dsram_axi_bridge dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .stall   (stall),
    .err     (err),
    .araddr  (araddr),
    .arsize  (arsize),
    .arvalid (arvalid),
    .arready (arready),
    .r_data  (r_data),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .w_data  (w_data),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Size rule from the byte count of the strobe: 1 byte, 2 bytes, 4 bytes; anything else is a word.
  function automatic logic [2:0] model_size(input logic [3:0] s);
    int n;
    n = $countones(s);
    if (n == 1) return 3'd0;
    if (n == 2) return 3'd1;
    return 3'd2;
  endfunction

  task automatic start_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; wen = w; addr = a; wdata = d;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_no_axi", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("err_one_cycle", err, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                         input int unsigned d_ar, input int unsigned d_r);
    start_req(4'b0000, a, $urandom);
    for (int unsigned k = 0; k <= d_ar; k++) begin
      @(negedge clk);
      arready = (k == d_ar);
      #1;
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, a & 32'hFFFF_FFFC);
      chk("ar_size", arsize, 2);
      chk("ar_stall", stall, 1);
      chk("ar_no_rready", rready, 0);
    end
    for (int unsigned k = 0; k <= d_r; k++) begin
      @(negedge clk);
      arready = 1'b0;
      rvalid  = (k == d_r);
      r_data  = (k == d_r) ? d : $urandom;
      rresp   = resp;
      #1;
      chk("r_ready", rready, 1);
      chk("r_arvalid_low", arvalid, 0);
      chk("r_stall", stall, 1);
    end
    @(negedge clk);
    rvalid = 1'b0; req = 1'b0;
    #1;
    chk("rd_done_stall", stall, 0);
    chk("rd_done_rdata", rdata, d);
    chk("rd_done_err", err, (resp != 2'b00));
    chk("rd_done_rready", rready, 0);
    last_rdata = d;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          input int unsigned d_aw, input int unsigned d_w,
                          input int unsigned d_b, input logic [1:0] resp);
    int unsigned kmax;
    kmax = (d_aw > d_w) ? d_aw : d_w;
    start_req(w, a, d);
    for (int unsigned k = 0; k <= kmax; k++) begin
      @(negedge clk);
      awready = (k == d_aw);
      wready  = (k == d_w);
      #1;
      chk("aw_valid", awvalid, (k <= d_aw));
      chk("w_valid", wvalid, (k <= d_w));
      chk("aw_addr", awaddr, a);
      chk("aw_size", awsize, model_size(w));
      chk("w_strb", wstrb, w);
      chk("w_data", w_data, d);
      chk("aw_stall", stall, 1);
      chk("aw_no_bready", bready, 0);
    end
    for (int unsigned j = 0; j <= d_b; j++) begin
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      bvalid  = (j == d_b);
      bresp   = resp;
      #1;
      chk("b_ready", bready, 1);
      chk("b_no_aw_w", {awvalid, wvalid}, 0);
      chk("b_stall", stall, 1);
    end
    @(negedge clk);
    bvalid = 1'b0; req = 1'b0; wen = 4'b0000;
    #1;
    chk("wr_done_stall", stall, 0);
    chk("wr_done_err", err, (resp != 2'b00));
    chk("wr_done_rdata_held", rdata, last_rdata);
    chk("wr_done_bready", bready, 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
    chk("idle_stall_low", stall, 0);
    chk("idle_quiet", {arvalid, rready, awvalid, wvalid, bready, err}, 0);
  endtask

  initial begin
    logic [3:0] strb_tab [8];
    logic [3:0] w;
    strb_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};

    resetn = 1'b0; req = 1'b0; wen = '0; addr = '0; wdata = '0;
    arready = 1'b0; r_data = '0; rresp = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    last_rdata = '0;
    #1;
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle_cycle();

    do_read(32'h1FC0_0104, 32'hDEAD_BEEF, 2'b00, 2, 1);
    idle_cycle();
    do_write(32'h0000_0012, 4'b0100, 32'h00AB_0000, 0, 0, 2, 2'b00);
    idle_cycle();
    do_write(32'h8000_1000, 4'b1111, 32'h1234_5678, 3, 0, 0, 2'b00);
    do_read(32'h0000_2002, 32'hCAFE_F00D, 2'b10, 0, 0);
    do_write(32'h0000_3006, 4'b0011, 32'h0000_BEEF, 0, 0, 0, 2'b11);
    do_read(32'h0000_4000, 32'h0BAD_CAFE, 2'b00, 0, 2);
    do_write(32'h0000_5002, 4'b1100, 32'h5555_0000, 1, 1, 1, 2'b00);

    // Abort a write while it waits for the write response.
    @(negedge clk);
    req = 1'b1; wen = 4'b1111; addr = 32'h0000_6000; wdata = 32'hFFFF_0000;
    @(negedge clk);
    awready = 1'b1; wready = 1'b1;
    #1 chk("abort_awvalid", awvalid, 1);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1 chk("abort_in_wr_b", bready, 1);
    #2 resetn = 1'b0; req = 1'b0; wen = '0;
    #1;
    chk("abort_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("abort_stall", stall, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_err", err, 0);
    last_rdata = '0;
    @(negedge clk);
    resetn = 1'b1;
    do_read(32'h1FC0_0200, 32'h600D_D474, 2'b00, 1, 0);
    do_write(32'h0000_7002, 4'b0011, 32'h0000_ABCD, 0, 0, 0, 2'b00);

    for (int unsigned t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      if ($urandom_range(0, 1) == 0) begin
        do_read($urandom, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        w = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : strb_tab[$urandom_range(0, 7)];
        do_write($urandom, w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      end
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
